// File: rtl/lvg_drain_if.sv
// Capture/drain handshake bundle for lvg_drain.
// master drives matrices in and accepts elements out.
interface lvg_drain_if #(
  parameter int W = 32
);
  logic          cap_valid;
  logic [16*W-1:0] mat;
  logic          order;
  logic          cap_ready;
  logic [W-1:0]  out_data;
  logic          out_valid;
  logic          out_ready;
  logic [1:0]    out_row;
  logic [1:0]    out_col;
  logic          out_last;
  logic          drop_err;

  modport master (
    output cap_valid, mat, order, out_ready,
    input  cap_ready, out_data, out_valid,
    input  out_row, out_col, out_last, drop_err
  );

  modport slave (
    input  cap_valid, mat, order, out_ready,
    output cap_ready, out_data, out_valid,
    output out_row, out_col, out_last, drop_err
  );
endinterface

// File: rtl/lvg_drain.sv
// Ping-pong capture of a 4x4 result matrix and
// element-serial drain in row- or column-major order.
module lvg_drain #(
  parameter int W = 32
) (
  input  logic        clk,
  input  logic        rst,
  lvg_drain_if.slave  bus
);

  logic [16*W-1:0] buf_q [2];
  logic [1:0]      ord_q;
  logic            wp_q, wp_d;
  logic            rp_q, rp_d;
  logic [1:0]      occ_q, occ_d;
  logic [3:0]      k_q, k_d;
  logic            drop_q, drop_d;

  logic            vld;
  logic            rdy;
  logic            cap;
  logic            xfer;
  logic            last;
  logic [1:0]      row;
  logic [1:0]      col;
  logic [3:0]      idx;
  logic [W-1:0]    elem;

  // Readiness comes from start-of-cycle occupancy only.
  assign rdy  = (occ_q != 2'd2);
  assign vld  = (occ_q != 2'd0);
  assign cap  = bus.cap_valid && rdy;
  assign xfer = vld && bus.out_ready;
  assign last = xfer && (k_q == 4'd15);

  // Next-state for pointers, occupancy, index, sticky drop.
  always_comb begin
    wp_d   = wp_q ^ cap;
    rp_d   = rp_q ^ last;
    occ_d  = occ_q;
    k_d    = k_q;
    drop_d = drop_q | (bus.cap_valid && !rdy);
    if (last) begin
      k_d = 4'd0;
    end else if (xfer) begin
      k_d = k_q + 4'd1;
    end
    if (cap && !last) begin
      occ_d = occ_q + 2'd1;
    end else if (!cap && last) begin
      occ_d = occ_q - 2'd1;
    end
  end

  // Control state, synchronously cleared.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wp_q   <= 1'b0;
      rp_q   <= 1'b0;
      occ_q  <= 2'd0;
      k_q    <= 4'd0;
      drop_q <= 1'b0;
    end else begin
      wp_q   <= wp_d;
      rp_q   <= rp_d;
      occ_q  <= occ_d;
      k_q    <= k_d;
      drop_q <= drop_d;
    end
  end

  // Matrix storage; contents survive reset by design.
  always_ff @(posedge clk) begin
    if (rst && cap) begin
      buf_q[wp_q] <= bus.mat;
      ord_q[wp_q] <= bus.order;
    end
  end

  // Map k to (row,col) and select the offered element.
  always_comb begin
    if (ord_q[rp_q]) begin
      row = k_q[1:0];
      col = k_q[3:2];
    end else begin
      row = k_q[3:2];
      col = k_q[1:0];
    end
    idx  = {row, col};
    elem = buf_q[rp_q][W*idx +: W];
  end

  assign bus.cap_ready = rdy;
  assign bus.out_valid = vld;
  assign bus.drop_err  = drop_q;
  assign bus.out_data  = vld ? elem : '0;
  assign bus.out_row   = vld ? row : 2'd0;
  assign bus.out_col   = vld ? col : 2'd0;
  assign bus.out_last  = vld && (k_q == 4'd15);

endmodule

// File: doc/lvg_drain.md
LVG_DRAIN -- requirements
Module: lvg_drain

Interface
REQ-001 SHALL have parameter W, default 32, meaning bit width of one matrix element (IEEE-754 single by default).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-low (state cleared on a rising clk edge while rst==0).
REQ-004 SHALL have port cap_valid  input  1  4x4 result matrix from lvg array present on mat this cycle.
REQ-005 SHALL have port mat  input  16*W  result matrix; element (r,c), r,c in 0..3, at mat[W*(4r+c) +: W], so b11 occupies [W-1:0] and b44 the top word.
REQ-006 SHALL have port order  input  1  0=row-major drain, 1=column-major drain; sampled with the matrix at capture.
REQ-007 SHALL have port cap_ready  output  1  at least one of two matrix buffers is free.
REQ-008 SHALL have port out_data  output  W  current element being offered.
REQ-009 SHALL have port out_valid  output  1  out_data/out_row/out_col/out_last valid.
REQ-010 SHALL have port out_ready  input  1  downstream accepts element this cycle.
REQ-011 SHALL have port out_row  output  2  row index of out_data.
REQ-012 SHALL have port out_col  output  2  column index of out_data.
REQ-013 SHALL have port out_last  output  1  out_data is the 16th element of its matrix.
REQ-014 SHALL have port drop_err  output  1  sticky: a matrix was offered while no buffer was free.

Function
REQ-015 SHALL hold two W*16 ping-pong buffers, each with its own stored order bit, a write pointer, a read pointer and an occupancy count occ in 0..2.
REQ-016 SHALL drive cap_ready = (occ<2), computed from occupancy at start of cycle only (no same-cycle bypass from a draining buffer).
REQ-017 SHALL capture mat and order into the buffer at the write pointer on a rising edge where cap_valid && cap_ready, then toggle the write pointer.
REQ-018 SHALL discard mat and set drop_err on a rising edge where cap_valid && !cap_ready; drop_err stays 1 until reset.
REQ-019 SHALL drive out_valid = (occ>0); first element appears the cycle after capture (latency 1 cycle from capture edge).
REQ-020 SHALL step an element index k 0..15 per transfer (out_valid && out_ready); order=0 maps k to (row,col)=(k/4,k%4), order=1 to (k%4,k/4).
REQ-021 SHALL drive out_data, out_row, out_col from the read buffer at current k, and out_last = (k==15).
REQ-022 SHALL hold out_data, out_row, out_col, out_last stable while out_valid && !out_ready.
REQ-023 SHALL, on the transfer with out_last=1, reset k to 0, toggle the read pointer, and decrement occ.
REQ-024 SHALL, when capture and last-element transfer occur on the same edge, leave occ unchanged and perform both actions.
REQ-025 SHALL sustain one element per cycle across matrix boundaries with no bubble when the second buffer is full.
REQ-026 SHALL drive out_data, out_row, out_col, out_last to 0 whenever out_valid==0.

Reset
REQ-027 SHALL, on any edge with rst==0, set occ=0, both pointers=0, k=0, drop_err=0, giving out_valid=0, cap_ready=1, all other outputs 0; buffer contents need not be cleared.
REQ-028 SHALL, on reset mid-stream, abandon any partially drained matrix; no element of it is presented after rst returns to 1.
REQ-029 SHALL ignore cap_valid on edges where rst==0.

Verification
REQ-030 SHALL pass: element (r,c)=32'h3F800000+4r+c, order=0, out_ready=1 -> 16 transfers on consecutive cycles starting 1 cycle after capture, data ...00,...01,...02,...03,...04,...,...0F, out_last only on ...0F.
REQ-031 SHALL pass: same matrix, order=1 -> sequence ...00,...04,...08,...0C,...01,... ending ...0F with out_row=3,out_col=3,out_last=1.
REQ-032 SHALL pass: capture A and B back-to-back, out_ready=0 for 10 cycles then 1 -> cap_ready=0 after second capture, out_data held at A(0,0), then 32 contiguous transfers A then B, cap_ready=1 on cycle after A's last.
REQ-033 SHALL pass: both buffers full, cap_valid pulse with C -> drop_err=1 and stays 1, C never appears at output.
REQ-034 SHALL pass: out_ready toggling 1,0,1,0 -> each element transferred exactly once, no duplicates or skips.
REQ-035 SHALL pass: rst=0 for one cycle after 5 transfers of A -> next cycle out_valid=0, cap_ready=1, drop_err=0; new capture D drains from D(0,0).
